instruction_fetch: RTL and testbench

Front end of the model computer. Holds the program counter, reads the four bytes of each instruction from the synchronous program ROM one byte per cycle, and presents them as opcode1..opcode4 to the decode/operand-select logic. When execute accepts an instruction it returns the branch decision and next-PC value, which are the same condition and cntInput signals the operand controller produces; the fetch unit then loads the PC and starts the next fetch.

---
 rtl/model_computer_pkg.sv | 14 +
 rtl/instruction_fetch.sv | 105 ++++++++++
 tb/tb_instruction_fetch.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/model_computer_pkg.sv
// rtl/model_computer_pkg.sv - shared widths, fetch state encoding and reset PC
package model_computer_pkg;

    localparam int WORD_W      = 8;
    localparam int INSTR_BYTES = 4;

    localparam logic [WORD_W-1:0] RESET_PC = '0;

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC holder and byte-serial instruction fetch from synchronous ROM
module instruction_fetch #(
    parameter int WORD_W      = model_computer_pkg::WORD_W,
    parameter int INSTR_BYTES = model_computer_pkg::INSTR_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_rd,
    output logic [WORD_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [WORD_W-1:0] opcode1,
    output logic [WORD_W-1:0] opcode2,
    output logic [WORD_W-1:0] opcode3,
    output logic [WORD_W-1:0] opcode4,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] ret_addr
);
    import model_computer_pkg::fetch_state_t;
    import model_computer_pkg::FETCH;
    import model_computer_pkg::VALID;
    import model_computer_pkg::RESET_PC;

    localparam int CNT_W = $clog2(INSTR_BYTES + 1);
    localparam int IDX_W = $clog2(INSTR_BYTES);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [WORD_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [IDX_W-1:0]  r_cap_idx;
    logic              r_rd_pending;
    logic [WORD_W-1:0] r_opcode [INSTR_BYTES];
    logic              w_issue;
    logic              w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Issue is suppressed during reset so no read can be left in flight across it.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            FETCH: begin
                w_issue = !rst && (r_issue_cnt < CNT_W'(INSTR_BYTES));
                if (r_rd_pending && (r_cap_idx == IDX_W'(INSTR_BYTES - 1))) begin
                    w_next_state = VALID;
                end
            end
            VALID: begin
                w_accept = instr_ready;
                if (w_accept) begin
                    w_next_state = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_issue_cnt  <= '0;
            r_cap_idx    <= '0;
            r_rd_pending <= 1'b0;
            for (int i = 0; i < INSTR_BYTES; i++) begin
                r_opcode[i] <= '0;
            end
        end else begin
            r_rd_pending <= w_issue;
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
            if (r_state == FETCH && r_rd_pending) begin
                r_opcode[r_cap_idx] <= rom_data;
                r_cap_idx           <= r_cap_idx + IDX_W'(1);
            end
            if (w_accept) begin
                r_pc        <= branch_taken ? branch_target : r_pc + WORD_W'(INSTR_BYTES);
                r_issue_cnt <= '0;
                r_cap_idx   <= '0;
            end
        end
    end

    assign rom_rd      = w_issue;
    assign rom_addr    = w_issue ? r_pc + WORD_W'(r_issue_cnt) : (rst ? '0 : r_pc);
    assign instr_valid = (r_state == VALID);
    assign opcode1     = r_opcode[0];
    assign opcode2     = r_opcode[1];
    assign opcode3     = r_opcode[2];
    assign opcode4     = r_opcode[3];
    assign pc          = r_pc;
    assign ret_addr    = r_pc + WORD_W'(INSTR_BYTES);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rom_rd;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] opcode1, opcode2, opcode3, opcode4;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic [7:0] pc;
    logic [7:0] ret_addr;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk),
        .rst(rst),
        .rom_rd(rom_rd),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .opcode1(opcode1),
        .opcode2(opcode2),
        .opcode3(opcode3),
        .opcode4(opcode4),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .pc(pc),
        .ret_addr(ret_addr)
    );

    logic [7:0] rom [256];
    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_pc;
    logic [7:0] q_addr[$];
    int         q_cyc[$];

    function automatic logic [31:0] exp_word(input logic [7:0] a);
        logic [7:0] b1, b2, b3;
        b1 = a + 8'd1;
        b2 = a + 8'd2;
        b3 = a + 8'd3;
        return {rom[a], rom[b1], rom[b2], rom[b3]};
    endfunction

    function automatic logic [31:0] got_word();
        return {opcode1, opcode2, opcode3, opcode4};
    endfunction

    // Entered at +1ns into a cycle with inputs already driven; returns at +5ns of the valid cycle.
    task automatic wait_valid(input bit hold, output int lat);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            #4;
            if (rom_rd) begin
                q_addr.push_back(rom_addr);
                q_cyc.push_back(c);
            end
            if (instr_valid) begin
                lat = c;
                return;
            end
            @(posedge clk); #1;
            instr_ready   = hold;
            branch_taken  = 1'($urandom);
            branch_target = 8'($urandom);
        end
    endtask

    task automatic accept(input bit bt, input logic [7:0] tgt);
        @(posedge clk); #1;
        instr_ready   = 1'b1;
        branch_taken  = bt;
        branch_target = tgt;
        exp_pc = bt ? tgt : exp_pc + 8'd4;
        @(posedge clk); #1;
        instr_ready   = 1'b0;
        branch_taken  = 1'($urandom);
        branch_target = 8'($urandom);
        q_addr.delete();
        q_cyc.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #5;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        n_vec++; if (got_word() !== 32'h0) begin n_err++; $display("FAIL reset_opcodes got=%h exp=00000000", got_word()); end
        n_vec++; if (pc !== 8'h00) begin n_err++; $display("FAIL reset_pc got=%h exp=00", pc); end
        n_vec++; if (ret_addr !== 8'h04) begin n_err++; $display("FAIL reset_ret got=%h exp=04", ret_addr); end
        n_vec++; if (rom_rd !== 1'b0 || rom_addr !== 8'h00) begin
            n_err++; $display("FAIL reset_rom got rd=%b addr=%h exp rd=0 addr=00", rom_rd, rom_addr);
        end
    endtask

    task automatic test_first_fetch();
        int lat;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pc = 8'h00;
        q_addr.delete(); q_cyc.delete();
        wait_valid(0, lat);
        n_vec++; if (lat != 6) begin n_err++; $display("FAIL first_latency got=%0d exp=6", lat); end
        n_vec++;
        if (q_addr.size() != 4) begin n_err++; $display("FAIL first_nreads got=%0d exp=4", q_addr.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_vec++; if (q_addr[k] !== 8'(k) || q_cyc[k] != k + 1) begin
                n_err++; $display("FAIL first_addr%0d got=%h@%0d exp=%h@%0d", k, q_addr[k], q_cyc[k], k, k + 1);
            end
        end
        n_vec++; if (got_word() !== 32'h11223344) begin n_err++; $display("FAIL first_opcodes got=%h exp=11223344", got_word()); end
        n_vec++; if (pc !== 8'h00 || ret_addr !== 8'h04) begin n_err++; $display("FAIL first_pc got=%h/%h exp=00/04", pc, ret_addr); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            instr_ready = 1'b0; branch_taken = 1'($urandom); branch_target = 8'($urandom);
            #4;
            n_vec++; if (instr_valid !== 1'b1 || got_word() !== 32'h11223344 || pc !== 8'h00) begin
                n_err++; $display("FAIL first_hold got=%b %h %h exp=1 11223344 00", instr_valid, got_word(), pc);
            end
        end
    endtask

    task automatic test_sequential();
        int lat;
        accept(1'b0, 8'h00);
        wait_valid(0, lat);
        n_vec++; if (lat != 6) begin n_err++; $display("FAIL seq_latency got=%0d exp=6", lat); end
        n_vec++;
        if (q_addr.size() != 4) begin n_err++; $display("FAIL seq_nreads got=%0d exp=4", q_addr.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_vec++; if (q_addr[k] !== 8'(4 + k)) begin n_err++; $display("FAIL seq_addr%0d got=%h exp=%h", k, q_addr[k], 4 + k); end
        end
        n_vec++; if (pc !== 8'h04 || ret_addr !== 8'h08) begin n_err++; $display("FAIL seq_pc got=%h/%h exp=04/08", pc, ret_addr); end
        n_vec++; if (got_word() !== exp_word(8'h04)) begin n_err++; $display("FAIL seq_opcodes got=%h exp=%h", got_word(), exp_word(8'h04)); end
    endtask

    task automatic test_branch();
        int lat;
        accept(1'b1, 8'h80);
        wait_valid(0, lat);
        n_vec++; if (lat != 6) begin n_err++; $display("FAIL br_latency got=%0d exp=6", lat); end
        n_vec++;
        if (q_addr.size() != 4) begin n_err++; $display("FAIL br_nreads got=%0d exp=4", q_addr.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_vec++; if (q_addr[k] !== 8'(8'h80 + k)) begin n_err++; $display("FAIL br_addr%0d got=%h exp=%h", k, q_addr[k], 8'h80 + k); end
        end
        n_vec++; if (pc !== 8'h80 || ret_addr !== 8'h84) begin n_err++; $display("FAIL br_pc got=%h/%h exp=80/84", pc, ret_addr); end
        n_vec++; if (got_word() !== exp_word(8'h80)) begin n_err++; $display("FAIL br_opcodes got=%h exp=%h", got_word(), exp_word(8'h80)); end
    endtask

    task automatic test_wrap();
        int         lat;
        logic [7:0] exp_a [4];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        accept(1'b1, 8'hFE);
        wait_valid(0, lat);
        n_vec++;
        if (q_addr.size() != 4) begin n_err++; $display("FAIL wrap_nreads got=%0d exp=4", q_addr.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_vec++; if (q_addr[k] !== exp_a[k]) begin n_err++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, q_addr[k], exp_a[k]); end
        end
        n_vec++; if (pc !== 8'hFE || ret_addr !== 8'h02) begin n_err++; $display("FAIL wrap_pc got=%h/%h exp=FE/02", pc, ret_addr); end
        n_vec++; if (got_word() !== exp_word(8'hFE)) begin n_err++; $display("FAIL wrap_opcodes got=%h exp=%h", got_word(), exp_word(8'hFE)); end
        accept(1'b0, 8'h33);
        wait_valid(0, lat);
        n_vec++; if (lat != 6 || pc !== 8'h02) begin n_err++; $display("FAIL wrap_seq got=%0d/%h exp=6/02", lat, pc); end
    endtask

    task automatic test_ignored_branch();
        int         lat;
        logic [7:0] pc0;
        pc0 = exp_pc;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            instr_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'h55;
            #4;
            n_vec++; if (instr_valid !== 1'b1 || pc !== pc0) begin
                n_err++; $display("FAIL ign_hold got=%b/%h exp=1/%h", instr_valid, pc, pc0);
            end
        end
        accept(1'b0, 8'h55);
        wait_valid(0, lat);
        n_vec++; if (pc !== 8'(pc0 + 8'd4)) begin n_err++; $display("FAIL ign_advance got=%h exp=%h", pc, 8'(pc0 + 8'd4)); end
        n_vec++; if (got_word() !== exp_word(exp_pc)) begin n_err++; $display("FAIL ign_opcodes got=%h exp=%h", got_word(), exp_word(exp_pc)); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk); #1;
        instr_ready = 1'b1; branch_taken = 1'b0; branch_target = 8'($urandom);
        exp_pc = exp_pc + 8'd4;
        for (int it = 0; it < 5; it++) begin
            @(posedge clk); #1;
            instr_ready = 1'b1; branch_taken = 1'($urandom); branch_target = 8'($urandom);
            q_addr.delete(); q_cyc.delete();
            wait_valid(1, lat);
            n_vec++; if (lat != 6) begin n_err++; $display("FAIL b2b_latency%0d got=%0d exp=6", it, lat); end
            n_vec++; if (pc !== exp_pc || got_word() !== exp_word(exp_pc)) begin
                n_err++; $display("FAIL b2b_instr%0d got=%h:%h exp=%h:%h", it, pc, got_word(), exp_pc, exp_word(exp_pc));
            end
            exp_pc = branch_taken ? branch_target : exp_pc + 8'd4;
        end
        @(posedge clk); #1;
        instr_ready = 1'b0;
        q_addr.delete(); q_cyc.delete();
        wait_valid(0, lat);
        n_vec++; if (lat != 6 || pc !== exp_pc || got_word() !== exp_word(exp_pc)) begin
            n_err++; $display("FAIL b2b_last got=%0d/%h:%h exp=6/%h:%h", lat, pc, got_word(), exp_pc, exp_word(exp_pc));
        end
    endtask

    task automatic test_random();
        int         lat;
        bit         bt;
        logic [7:0] tgt;
        for (int it = 0; it < 20; it++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                instr_ready = 1'b0; branch_taken = 1'($urandom); branch_target = 8'($urandom);
            end
            bt  = 1'($urandom);
            tgt = 8'($urandom);
            accept(bt, tgt);
            wait_valid(0, lat);
            n_vec++; if (lat != 6) begin n_err++; $display("FAIL rnd_latency%0d got=%0d exp=6", it, lat); end
            n_vec++; if (pc !== exp_pc || ret_addr !== 8'(exp_pc + 8'd4)) begin
                n_err++; $display("FAIL rnd_pc%0d got=%h/%h exp=%h/%h", it, pc, ret_addr, exp_pc, 8'(exp_pc + 8'd4));
            end
            n_vec++; if (got_word() !== exp_word(exp_pc)) begin
                n_err++; $display("FAIL rnd_opcodes%0d got=%h exp=%h", it, got_word(), exp_word(exp_pc));
            end
        end
    endtask

    task automatic test_reset_midfetch();
        int lat;
        accept(1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        #4;
        n_vec++; if (rom_rd !== 1'b0 || rom_addr !== 8'h00) begin
            n_err++; $display("FAIL mid_rom_in_rst got rd=%b addr=%h exp rd=0 addr=00", rom_rd, rom_addr);
        end
        @(posedge clk); #5;
        n_vec++; if (instr_valid !== 1'b0 || got_word() !== 32'h0 || pc !== 8'h00 || ret_addr !== 8'h04) begin
            n_err++; $display("FAIL mid_reset_vals got=%b %h %h %h exp=0 00000000 00 04", instr_valid, got_word(), pc, ret_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pc = 8'h00;
        q_addr.delete(); q_cyc.delete();
        wait_valid(0, lat);
        n_vec++; if (lat != 6) begin n_err++; $display("FAIL mid_latency got=%0d exp=6", lat); end
        n_vec++;
        if (q_addr.size() != 4) begin n_err++; $display("FAIL mid_nreads got=%0d exp=4", q_addr.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_vec++; if (q_addr[k] !== 8'(k) || q_cyc[k] != k + 1) begin
                n_err++; $display("FAIL mid_addr%0d got=%h@%0d exp=%h@%0d", k, q_addr[k], q_cyc[k], k, k + 1);
            end
        end
        n_vec++; if (got_word() !== 32'h11223344 || pc !== 8'h00) begin
            n_err++; $display("FAIL mid_refetch got=%h/%h exp=11223344/00", got_word(), pc);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_wrap();
        test_ignored_branch();
        test_back_to_back();
        test_random();
        test_reset_midfetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
